ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It is the transmit counterpart of the existing PS/2 keyboard receive path and shares the same ps2_clk/ps2_data open-drain lines. It runs on the 100 MHz board clock. The top level builds the tri-states from the *_oe outputs.

---
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device
// using open-drain line control (the *_oe outputs pull the line low).
// Optional build macro: PS2_TX_ACK_CHECK_EN turns a missing device ACK
// into a tx_err pulse instead of a normal completion.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAX_CNT + 1);
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_XFER,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t        state, state_next;
  logic [9:0]    shift, shift_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [TW-1:0] timer, timer_next;
  logic          data_oe_next, done_next, err_next;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          fe, timed_out;

  // Two-flop synchronizers on both raw lines plus a delayed copy of the clock
  // for edge detection; idle lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fe        = clk_prev & ~clk_s2;
  assign timed_out = (timer == TIMEOUT_LAST);

  // Next-state, frame shifting, timer and registered-output next values.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    timer_next   = timer;
    data_oe_next = ps2_data_oe;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_next   = '0;
        bit_cnt_next = '0;
        if (tx_start) begin
          shift_next = {1'b1, ~^tx_data, tx_data};
          state_next = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          timer_next   = '0;
          data_oe_next = 1'b1;
          state_next   = ST_REQ;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      ST_REQ, ST_XFER: begin
        if (fe) begin
          data_oe_next = ~shift[0];
          shift_next   = {1'b1, shift[9:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          timer_next   = '0;
          state_next   = (bit_cnt == 4'd9) ? ST_ACK : ST_XFER;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      ST_ACK: begin
        if (fe) begin
          timer_next = '0;
`ifdef PS2_TX_ACK_CHECK_EN
          if (data_s2) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT_IDLE;
          end
`else
          state_next = ST_WAIT_IDLE;
`endif
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_IDLE || state_next == ST_INHIBIT || state_next == ST_WAIT_IDLE)
      data_oe_next = 1'b0;
  end

  // State, datapath and glitch-free registered outputs; reset releases the lines at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_next;
      shift       <= shift_next;
      bit_cnt     <= bit_cnt_next;
      timer       <= timer_next;
      tx_busy     <= (state_next != ST_IDLE);
      tx_done     <= done_next;
      tx_err      <= err_next;
      ps2_clk_oe  <= (state_next == ST_INHIBIT);
      ps2_data_oe <= data_oe_next;
    end
  end

endmodule
